// File: rtl/uc_arbiter_rr.sv
// Unit-clause arbiter: memory load, then round-robin engine intake into a UCQ broadcast to all engines; `UCA_DEDUP_EN drops duplicates.
// Latency: a literal accepted in cycle N is visible on uca2eng in N+1 when the UCQ was empty.
// Backpressure: readys follow !full (a same-cycle pop does not help); all readys drop once a conflict is latched.
module uc_arbiter_rr #(
   parameter int NUM_ENGINE = 4,
   parameter int LIT_W      = 10,
   parameter int UCQ_DEPTH  = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               mem2uca_valid,
   input  logic                               mem2uca_done,
   input  logic signed [LIT_W-1:0]            mem2uca,
   output logic                               mem2uca_ready,
   input  logic [NUM_ENGINE-1:0]              eng2uca_valid,
   input  logic [NUM_ENGINE-1:0][LIT_W-1:0]   eng2uca_lit,
   output logic [NUM_ENGINE-1:0]              eng2uca_ready,
   input  logic                               eng2uca_rd,
   output logic                               uca2eng_valid,
   output logic signed [LIT_W-1:0]            uca2eng,
   output logic                               uca_idle,
   output logic                               conflict
);

   localparam int AW = $clog2(UCQ_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(NUM_ENGINE);

   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_CONFLICT} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic signed [LIT_W-1:0] r_mem [UCQ_DEPTH];
   logic [AW-1:0]           r_rd_ptr;
   logic [AW-1:0]           r_wr_ptr;
   logic [CW-1:0]           r_count;
   logic [PW-1:0]           r_rr_ptr;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_gnt_found;
   logic [PW-1:0]           w_gnt_idx;
   logic [PW-1:0]           w_rr_nxt;
   int                      w_rot_idx;
   logic                    w_eng_acc;
   logic                    w_mem_acc;
   logic                    w_in_vld;
   logic signed [LIT_W-1:0] w_in_lit;
   logic [AW-1:0]           w_off;
   logic                    w_hit;
   logic                    w_drop;
   logic                    w_push;
   logic                    w_pop;
   logic [AW-1:0]           w_head_ptr;

   assign w_full  = (r_count == CW'(UCQ_DEPTH));
   assign w_empty = (r_count == '0);

   // Rotating search for the first valid engine, starting at the rr pointer
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_rot_idx   = 0;
      for (int i = 0; i < NUM_ENGINE; i++) begin
         w_rot_idx = (int'(r_rr_ptr) + i) % NUM_ENGINE;
         if (!w_gnt_found && eng2uca_valid[w_rot_idx]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = PW'(w_rot_idx);
         end
      end
   end

   assign w_eng_acc = (r_state == ST_RUN) && w_gnt_found && !w_full;
   assign w_mem_acc = (r_state == ST_LOAD) && mem2uca_valid && !w_full;
   assign w_in_vld  = w_eng_acc || w_mem_acc;
   assign w_in_lit  = (r_state == ST_LOAD) ? mem2uca : $signed(eng2uca_lit[w_gnt_idx]);
   assign w_rr_nxt  = (w_gnt_idx == PW'(NUM_ENGINE - 1)) ? '0 : w_gnt_idx + PW'(1);

   always_comb begin
      eng2uca_ready = '0;
      if (w_eng_acc) eng2uca_ready[w_gnt_idx] = 1'b1;
   end

   // Compare the incoming literal with every occupied entry, head included.
   // The entry != literal term keeps the most-negative code from matching itself.
   always_comb begin
      w_hit  = 1'b0;
      w_drop = 1'b0;
      w_off  = '0;
      for (int j = 0; j < UCQ_DEPTH; j++) begin
         w_off = AW'(j) - r_rd_ptr;
         if ({1'b0, w_off} < r_count) begin
            if (r_mem[j] == -w_in_lit && r_mem[j] != w_in_lit) w_hit = 1'b1;
`ifdef UCA_DEDUP_EN
            if (r_mem[j] == w_in_lit) w_drop = 1'b1;
`endif
         end
      end
      if (!w_in_vld || w_in_lit == '0) begin
         w_hit  = 1'b0;
         w_drop = 1'b1;
      end
   end

   assign w_push = w_in_vld && !w_hit && !w_drop;
   assign w_pop  = eng2uca_rd && uca2eng_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_rr_ptr <= '0;
         for (int j = 0; j < UCQ_DEPTH; j++) r_mem[j] <= '0;
      end else begin
         if (w_eng_acc) r_rr_ptr <= w_rr_nxt;
         if (w_hit) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_wr_ptr] <= w_in_lit;
               r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_LOAD;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOAD: begin
            if (w_hit)             w_state_nxt = ST_CONFLICT;
            else if (mem2uca_done) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_hit) w_state_nxt = ST_CONFLICT;
         end
         default: w_state_nxt = ST_CONFLICT;
      endcase
   end

   // When empty, show the slot just popped so the output holds its last head
   assign w_head_ptr    = w_empty ? r_rd_ptr - AW'(1) : r_rd_ptr;
   assign uca2eng       = r_mem[w_head_ptr];
   assign uca2eng_valid = !w_empty && (r_state != ST_CONFLICT);
   assign mem2uca_ready = (r_state == ST_LOAD) && !w_full;
   assign uca_idle      = (r_state == ST_RUN) && w_empty && (eng2uca_valid == '0);
   assign conflict      = (r_state == ST_CONFLICT);

endmodule

// File: tb/tb_uc_arbiter_rr.sv
// Directed bench for uc_arbiter_rr: load, rotation, full, conflict, duplicates, zero literal, wrap.
module tb_uc_arbiter_rr;

   logic             clk;
   logic             rst;
   logic             mem2uca_valid;
   logic             mem2uca_done;
   logic [9:0]       mem2uca;
   logic             mem2uca_ready;
   logic [3:0]       eng2uca_valid;
   logic [3:0][9:0]  eng2uca_lit;
   logic [3:0]       eng2uca_ready;
   logic             eng2uca_rd;
   logic             uca2eng_valid;
   logic signed [9:0] uca2eng;
   logic             uca_idle;
   logic             conflict;

   int n_cmp = 0;
   int n_err = 0;

   uc_arbiter_rr #(.NUM_ENGINE(4), .LIT_W(10), .UCQ_DEPTH(16)) dut (
      .clk(clk), .rst(rst),
      .mem2uca_valid(mem2uca_valid), .mem2uca_done(mem2uca_done),
      .mem2uca(mem2uca), .mem2uca_ready(mem2uca_ready),
      .eng2uca_valid(eng2uca_valid), .eng2uca_lit(eng2uca_lit),
      .eng2uca_ready(eng2uca_ready), .eng2uca_rd(eng2uca_rd),
      .uca2eng_valid(uca2eng_valid), .uca2eng(uca2eng),
      .uca_idle(uca_idle), .conflict(conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      mem2uca_valid = 1'b0;
      mem2uca_done  = 1'b0;
      mem2uca       = '0;
      eng2uca_valid = '0;
      eng2uca_lit   = '0;
      eng2uca_rd    = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic to_run();
      mem2uca_done = 1'b1;
      tick();
      mem2uca_done = 1'b0;
   endtask

   task automatic set_lit(input int e, input int v);
      logic [31:0] t;
      t = v;
      eng2uca_lit[e] = t[9:0];
   endtask

   task automatic set_mem(input int v);
      logic [31:0] t;
      t = v;
      mem2uca = t[9:0];
   endtask

`ifdef UCA_DEDUP_EN
   int exp_rot[$] = '{3, -2, 6, 8};
`else
   int exp_rot[$] = '{3, -2, 6, 3, 8};
`endif

   initial begin
      // reset state
      clr();
      rst = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_mem_ready", mem2uca_ready, 1);
      chk("rst_eng_ready", eng2uca_ready, 0);
      chk("rst_valid", uca2eng_valid, 0);
      chk("rst_uca2eng", uca2eng, 0);
      chk("rst_idle", uca_idle, 0);
      chk("rst_conflict", conflict, 0);
      rst = 1'b0;

      // 1: memory load
      mem2uca_valid = 1'b1;
      set_mem(10);
      #1 chk("load_ready", mem2uca_ready, 1);
      chk("load_valid_before", uca2eng_valid, 0);
      tick();
      chk("load_valid_n1", uca2eng_valid, 1);
      chk("load_head", uca2eng, 10);
      for (int k = 2; k <= 5; k++) begin
         set_mem(k * 10);
         mem2uca_done = (k == 5);
         tick();
      end
      clr();
      #1 chk("run_mem_ready", mem2uca_ready, 0);
      chk("run_idle_busy", uca_idle, 0);
      eng2uca_rd = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         #1 chk("load_order", uca2eng, k * 10);
         tick();
      end
      eng2uca_rd = 1'b0;
      #1 chk("drain_valid", uca2eng_valid, 0);
      chk("drain_hold", uca2eng, 50);
      chk("drain_idle", uca_idle, 1);
      eng2uca_valid = 4'b0001;
      set_lit(0, 11);
      #1 chk("run_eng_ready", eng2uca_ready, 4'b0001);

      // 2: round-robin rotation
      do_reset();
      to_run();
      eng2uca_valid = 4'b1110;
      set_lit(1, 3);
      set_lit(2, -2);
      set_lit(3, 6);
      #1 chk("rr_g1", eng2uca_ready, 4'b0010);
      tick();
      chk("rr_g2", eng2uca_ready, 4'b0100);
      tick();
      chk("rr_g3", eng2uca_ready, 4'b1000);
      tick();
      chk("rr_skip0", eng2uca_ready, 4'b0010);
      chk("rr_onehot", $onehot0(eng2uca_ready), 1);
      tick();
      eng2uca_valid = 4'b0011;
      set_lit(0, 8);
      #1 chk("rr_wrap0", eng2uca_ready, 4'b0001);
      tick();
      eng2uca_valid = '0;
      eng2uca_rd = 1'b1;
      foreach (exp_rot[k]) begin
         #1 chk("rr_order", uca2eng, exp_rot[k]);
         tick();
      end
      eng2uca_rd = 1'b0;
      #1 chk("rr_empty", uca2eng_valid, 0);

      // 3: full
      do_reset();
      mem2uca_valid = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         set_mem(k);
         tick();
      end
      set_mem(17);
      #1 chk("full_mem_ready", mem2uca_ready, 0);
      mem2uca_valid = 1'b0;
      mem2uca_done = 1'b1;
      tick();
      mem2uca_done = 1'b0;
      eng2uca_valid = 4'b0001;
      set_lit(0, 100);
      #1 chk("full_eng_ready", eng2uca_ready, 0);
      eng2uca_rd = 1'b1;
      #1 chk("full_pop_ready", eng2uca_ready, 0);
      chk("full_head", uca2eng, 1);
      tick();
      eng2uca_rd = 1'b0;
      #1 chk("full_reassert", eng2uca_ready, 4'b0001);
      chk("full_head2", uca2eng, 2);
      tick();
      #1 chk("full_again", eng2uca_ready, 0);

      // 4: conflict
      do_reset();
      mem2uca_valid = 1'b1;
      mem2uca_done = 1'b1;
      set_mem(7);
      tick();
      clr();
      eng2uca_valid = 4'b0100;
      set_lit(2, -7);
      #1 chk("cf_handshake", eng2uca_ready, 4'b0100);
      tick();
      chk("cf_flag", conflict, 1);
      chk("cf_valid", uca2eng_valid, 0);
      chk("cf_eng_ready", eng2uca_ready, 0);
      chk("cf_mem_ready", mem2uca_ready, 0);
      tick();
      chk("cf_sticky", conflict, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1 chk("cf_cleared", conflict, 0);
      chk("cf_rst_ready", mem2uca_ready, 1);
      clr();
      mem2uca_valid = 1'b1;
      mem2uca_done = 1'b1;
      set_mem(7);
      tick();
      clr();
      eng2uca_valid = 4'b0001;
      set_lit(0, -7);
      eng2uca_rd = 1'b1;
      tick();
      chk("cf_popped_head", conflict, 1);

      // 5: duplicate literal
      do_reset();
      mem2uca_valid = 1'b1;
      mem2uca_done = 1'b1;
      set_mem(5);
      tick();
      clr();
      eng2uca_valid = 4'b0001;
      set_lit(0, 5);
      #1 chk("dup_handshake", eng2uca_ready, 4'b0001);
      tick();
      eng2uca_valid = '0;
      eng2uca_rd = 1'b1;
      #1 chk("dup_first", uca2eng, 5);
      tick();
`ifdef UCA_DEDUP_EN
      chk("dup_dropped", uca2eng_valid, 0);
`else
      chk("dup_second_valid", uca2eng_valid, 1);
      chk("dup_second", uca2eng, 5);
      tick();
      chk("dup_drained", uca2eng_valid, 0);
`endif
      chk("dup_conflict", conflict, 0);

      // 6: zero literal, empty read, wrap
      do_reset();
      to_run();
      eng2uca_valid = 4'b1000;
      set_lit(3, 0);
      eng2uca_rd = 1'b1;
      #1 chk("zero_handshake", eng2uca_ready, 4'b1000);
      tick();
      eng2uca_valid = '0;
      eng2uca_rd = 1'b0;
      #1 chk("zero_valid", uca2eng_valid, 0);
      chk("zero_idle", uca_idle, 1);
      chk("zero_uca2eng", uca2eng, 0);
      eng2uca_valid = 4'b0001;
      set_lit(0, 1);
      tick();
      for (int k = 2; k <= 41; k++) begin
         if (k <= 40) set_lit(0, k);
         else eng2uca_valid = '0;
         eng2uca_rd = 1'b1;
         #1 chk("wrap_head", uca2eng, k - 1);
         tick();
      end
      eng2uca_rd = 1'b0;
      #1 chk("wrap_empty", uca2eng_valid, 0);
      chk("wrap_idle", uca_idle, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
